// File: rtl/ysyx_22050039_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch -> decode -> execute/memory -> writeback,
// with halt handling, a response watchdog and cycle/instret counters.
`timescale 1ns/1ps
module ysyx_22050039_seq_ctrl #(
    parameter int XLEN    = 64,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ifetch_valid,
    input  logic            ifetch_ready,
    input  logic            ifetch_rvalid,
    input  logic            ifetch_err,
    output logic            inst_latch,
    input  logic            dec_is_load,
    input  logic            dec_is_store,
    input  logic            dec_is_muldiv,
    input  logic            dec_reg_wen,
    input  logic            dec_pc_wen,
    input  logic            dec_is_ebreak,
    input  logic            dec_is_invalid,
    output logic            exu_start,
    input  logic            exu_done,
    output logic            lsu_valid,
    output logic            lsu_write,
    input  logic            lsu_ready,
    input  logic            lsu_rvalid,
    input  logic            lsu_err,
    output logic            reg_total_wen,
    output logic            pc_wen,
    output logic            pc_sel_target,
    output logic            halt,
    output logic [1:0]      halt_cause,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret_cnt,
    output logic [2:0]      state_o
);

    // Handshakes: a request (ifetch_valid, lsu_valid) is held high until the
    // matching ready is seen at a rising edge; responses are single-cycle pulses
    // that are only honoured in the state waiting for them.
    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_IF   = 3'd1;
    localparam logic [2:0] S_IW   = 3'd2;
    localparam logic [2:0] S_ID   = 3'd3;
    localparam logic [2:0] S_EX   = 3'd4;
    localparam logic [2:0] S_MEM  = 3'd5;
    localparam logic [2:0] S_WB   = 3'd6;
    localparam logic [2:0] S_HALT = 3'd7;

    localparam logic [1:0] C_RUN     = 2'b00;
    localparam logic [1:0] C_EBREAK  = 2'b01;
    localparam logic [1:0] C_ILLEGAL = 2'b10;
    localparam logic [1:0] C_BUS     = 2'b11;

    logic [2:0]      state_q, state_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            req_done_q, req_done_d;
    logic            store_q, store_d;
    logic            reg_wen_q, reg_wen_d;
    logic            pc_tgt_q, pc_tgt_d;
    logic [1:0]      cause_q, cause_d;
    logic [XLEN-1:0] cycle_q, cycle_d;
    logic [XLEN-1:0] instret_q, instret_d;

    logic            wd_expired;
    logic [TO_W-1:0] wd_inc;

    // wd_q counts cycles already spent waiting, so the TIMEOUT-th cycle is the last chance.
    assign wd_expired = (wd_q >= TO_W'(TIMEOUT - 1));
    assign wd_inc     = wd_expired ? wd_q : wd_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RST;
            wd_q       <= '0;
            req_done_q <= 1'b0;
            store_q    <= 1'b0;
            reg_wen_q  <= 1'b0;
            pc_tgt_q   <= 1'b0;
            cause_q    <= C_RUN;
            cycle_q    <= '0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            req_done_q <= req_done_d;
            store_q    <= store_d;
            reg_wen_q  <= reg_wen_d;
            pc_tgt_q   <= pc_tgt_d;
            cause_q    <= cause_d;
            cycle_q    <= cycle_d;
            instret_q  <= instret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        req_done_d = req_done_q;
        store_d    = store_q;
        reg_wen_d  = reg_wen_q;
        pc_tgt_d   = pc_tgt_q;
        cause_d    = cause_q;
        case (state_q)
            S_RST: state_d = S_IF;
            S_IF: begin
                if (ifetch_ready) begin
                    state_d = S_IW;
                    wd_d    = '0;
                end
            end
            S_IW: begin
                if (ifetch_err) begin
                    state_d = S_HALT;
                    cause_d = C_BUS;
                end else if (ifetch_rvalid) begin
                    state_d = S_ID;
                end else if (wd_expired) begin
                    state_d = S_HALT;
                    cause_d = C_BUS;
                end else begin
                    wd_d = wd_inc;
                end
            end
            S_ID: begin
                store_d   = dec_is_store;
                reg_wen_d = dec_reg_wen;
                pc_tgt_d  = dec_pc_wen;
                if (dec_is_invalid) begin
                    state_d = S_HALT;
                    cause_d = C_ILLEGAL;
                end else if (dec_is_ebreak) begin
                    state_d = S_HALT;
                    cause_d = C_EBREAK;
                end else if (dec_is_muldiv) begin
                    state_d = S_EX;
                    wd_d    = '0;
                end else if (dec_is_load || dec_is_store) begin
                    state_d    = S_MEM;
                    wd_d       = '0;
                    req_done_d = 1'b0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_EX: begin
                if (exu_done) begin
                    state_d = S_WB;
                end else if (wd_expired) begin
                    state_d = S_HALT;
                    cause_d = C_BUS;
                end else begin
                    wd_d = wd_inc;
                end
            end
            S_MEM: begin
                if (lsu_err) begin
                    state_d = S_HALT;
                    cause_d = C_BUS;
                end else if ((req_done_q || lsu_ready) && lsu_rvalid) begin
                    state_d = S_WB;
                end else if (!req_done_q && lsu_ready) begin
                    req_done_d = 1'b1;
                    wd_d       = wd_inc;
                end else if (wd_expired) begin
                    state_d = S_HALT;
                    cause_d = C_BUS;
                end else begin
                    wd_d = wd_inc;
                end
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        if (state_q != S_RST && state_q != S_HALT) begin
            cycle_d = cycle_q + 1'b1;
        end
        if (state_q == S_WB ||
            (state_q == S_ID && dec_is_ebreak && !dec_is_invalid)) begin
            instret_d = instret_q + 1'b1;
        end
    end

    // wd_q is cleared on every EX entry and only grows, so wd_q == 0 marks the first EX cycle.
    always_comb begin
        ifetch_valid  = 1'b0;
        inst_latch    = 1'b0;
        exu_start     = 1'b0;
        lsu_valid     = 1'b0;
        lsu_write     = 1'b0;
        reg_total_wen = 1'b0;
        pc_wen        = 1'b0;
        pc_sel_target = 1'b0;
        case (state_q)
            S_IF: ifetch_valid = 1'b1;
            S_IW: inst_latch   = ifetch_rvalid && !ifetch_err;
            S_EX: exu_start    = (wd_q == '0);
            S_MEM: begin
                lsu_valid = !req_done_q;
                lsu_write = !req_done_q && store_q;
            end
            S_WB: begin
                reg_total_wen = reg_wen_q;
                pc_wen        = 1'b1;
                pc_sel_target = pc_tgt_q;
            end
            default: ;
        endcase
    end

    assign halt        = (state_q == S_HALT);
    assign halt_cause  = cause_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign state_o     = state_q;

    assert property (@(posedge clk) disable iff (!rst)
        $onehot0({inst_latch, exu_start, pc_wen}));
    assert property (@(posedge clk) disable iff (!rst)
        reg_total_wen |-> pc_wen);

endmodule
